// File: rtl/maquina_pkg.sv
// Shared definitions for the coffee-machine sequencer: state codes and width helpers.
package maquina_pkg;

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE           = 4'd0,
    ST_LIGAR          = 4'd1,
    ST_VERIFICAR_AGUA = 4'd2,
    ST_ENCHER         = 4'd3,
    ST_AQUECER        = 4'd4,
    ST_MOER           = 4'd5,
    ST_COLOCAR_FILTRO = 4'd6,
    ST_PASSAR         = 4'd7,
    ST_SERVIR         = 4'd8,
    ST_ABORTAR        = 4'd9
  } state_e;

  // Bits needed to hold a dose/cup count from 0 to cap inclusive.
  function automatic int unsigned dose_width(input int unsigned cap);
    return (cap < 1) ? 1 : $clog2(cap + 1);
  endfunction

  // Bits needed for a cycle counter that reaches max_dur-1.
  function automatic int unsigned cnt_width(input int unsigned max_dur);
    return (max_dur <= 2) ? 1 : $clog2(max_dur);
  endfunction

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/maquina_cafe_param_if.sv
// Front-panel / actuator bus of the coffee-machine sequencer.
interface maquina_cafe_param_if #(
  parameter int unsigned CUPS_W = 3,
  parameter int unsigned LVL_W  = 3
);
  logic              start;
  logic              abort;
  logic [CUPS_W-1:0] cups;
  logic [3:0]        state;
  logic              busy;
  logic              done;
  logic [LVL_W-1:0]  water_level;

  modport master (output start, abort, cups, input state, busy, done, water_level);
  modport slave  (input start, abort, cups, output state, busy, done, water_level);
endinterface

// File: rtl/maquina_timer.sv
// Cycle counter with synchronous clear and a terminal-count flag against a per-state limit.
module maquina_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic [W-1:0] i_term,
  output logic         o_tc_c
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_count <= '0;
    else if (i_clr) r_count <= '0;
    else            r_count <= r_count + W'(1);
  end

  assign o_tc_c = (r_count == i_term);

endmodule

// File: rtl/maquina_cafe_param.sv
// Parametrised coffee-machine sequencer: multi-cup brew FSM with reservoir level and abort.
module maquina_cafe_param
  import maquina_pkg::*;
#(
  parameter int unsigned WATER_CAP    = 4,
  parameter int unsigned MAX_CUPS     = 4,
  parameter int unsigned FILL_CYCLES  = 3,
  parameter int unsigned HEAT_CYCLES  = 4,
  parameter int unsigned GRIND_CYCLES = 2,
  parameter int unsigned BREW_CYCLES  = 3
) (
  input logic clk,
  input logic rst_n,
  maquina_cafe_param_if.slave bus
);

  localparam int unsigned CUPS_W = dose_width(MAX_CUPS);
  localparam int unsigned LVL_W  = dose_width(WATER_CAP);
  localparam int unsigned TMR_W  =
    cnt_width(max4(FILL_CYCLES, HEAT_CYCLES, GRIND_CYCLES, BREW_CYCLES));

  state_e             r_state, w_next_state;
  logic [LVL_W-1:0]   r_level, w_level_d;
  logic [CUPS_W-1:0]  r_cups, w_cups_d;
  logic [CUPS_W-1:0]  r_cup_cnt, w_cup_cnt_d;
  logic [CUPS_W-1:0]  w_cups_sat;
  logic               r_busy, r_done, w_busy_d, w_done_d;
  logic [TMR_W-1:0]   w_term;
  logic               w_tc, w_tmr_clr, w_aborting, w_abortable;

  maquina_timer #(.W(TMR_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_tmr_clr),
    .i_term (w_term),
    .o_tc_c (w_tc)
  );

  // Timer restarts on every state entry and on each dose/cup boundary.
  assign w_tmr_clr = w_tc || (w_next_state != r_state);

  always_comb begin
    if (bus.cups == '0)                         w_cups_sat = CUPS_W'(1);
    else if (bus.cups > CUPS_W'(MAX_CUPS))      w_cups_sat = CUPS_W'(MAX_CUPS);
    else                                        w_cups_sat = bus.cups;
  end

  assign w_abortable = (r_state == ST_LIGAR)   || (r_state == ST_VERIFICAR_AGUA) ||
                       (r_state == ST_ENCHER)  || (r_state == ST_AQUECER) ||
                       (r_state == ST_MOER)    || (r_state == ST_COLOCAR_FILTRO) ||
                       (r_state == ST_PASSAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_level   <= '0;
      r_cups    <= '0;
      r_cup_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_level   <= w_level_d;
      r_cups    <= w_cups_d;
      r_cup_cnt <= w_cup_cnt_d;
      r_busy    <= w_busy_d;
      r_done    <= w_done_d;
    end
  end

  // Next-state logic; abort overrides any normal transition.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:           if (bus.start) w_next_state = ST_LIGAR;
      ST_LIGAR:          w_next_state = ST_VERIFICAR_AGUA;
      ST_VERIFICAR_AGUA: w_next_state = (r_level >= LVL_W'(r_cups)) ? ST_AQUECER : ST_ENCHER;
      ST_ENCHER:         if (w_tc && (r_level >= LVL_W'(WATER_CAP - 1))) w_next_state = ST_AQUECER;
      ST_AQUECER:        if (w_tc) w_next_state = ST_MOER;
      ST_MOER:           if (w_tc) w_next_state = ST_COLOCAR_FILTRO;
      ST_COLOCAR_FILTRO: w_next_state = ST_PASSAR;
      ST_PASSAR:         if (w_tc && ((r_cup_cnt + CUPS_W'(1)) >= r_cups)) w_next_state = ST_SERVIR;
      ST_SERVIR:         w_next_state = ST_IDLE;
      ST_ABORTAR:        w_next_state = ST_IDLE;
      default:           w_next_state = ST_IDLE;
    endcase
    if (bus.abort && w_abortable) w_next_state = ST_ABORTAR;
  end

  // Datapath and registered-output next values.
  always_comb begin
    w_level_d   = r_level;
    w_cups_d    = r_cups;
    w_cup_cnt_d = r_cup_cnt;
    w_term      = '0;
    w_aborting  = (w_next_state == ST_ABORTAR);
    w_busy_d    = (w_next_state != ST_IDLE);
    w_done_d    = (w_next_state == ST_SERVIR);
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_cups_d    = w_cups_sat;
          w_cup_cnt_d = '0;
        end
      end
      ST_ENCHER: begin
        w_term = TMR_W'(FILL_CYCLES - 1);
        if (w_tc && !w_aborting && (r_level < LVL_W'(WATER_CAP))) w_level_d = r_level + LVL_W'(1);
      end
      ST_AQUECER: w_term = TMR_W'(HEAT_CYCLES - 1);
      ST_MOER:    w_term = TMR_W'(GRIND_CYCLES - 1);
      ST_PASSAR: begin
        w_term = TMR_W'(BREW_CYCLES - 1);
        if (w_tc && !w_aborting) begin
          w_cup_cnt_d = r_cup_cnt + CUPS_W'(1);
          if (r_level != '0) w_level_d = r_level - LVL_W'(1);
        end
      end
      default: w_term = '0;
    endcase
  end

  assign bus.state       = r_state;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.water_level = r_level;

endmodule

// File: tb/tb_maquina_cafe_param.sv
// Directed bench for maquina_cafe_param: state trajectories, level counter, abort and reset.
module tb_maquina_cafe_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  string phase = "reset";

  always #5 clk = ~clk;

  maquina_cafe_param_if #(.CUPS_W(3), .LVL_W(3)) bus ();

  maquina_cafe_param #(
    .WATER_CAP(4), .MAX_CUPS(4), .FILL_CYCLES(3),
    .HEAT_CYCLES(4), .GRIND_CYCLES(2), .BREW_CYCLES(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, exp);
    end
  endtask

  task automatic check_all(input int code, input int lvl);
    check("state", 32'(bus.state), 32'(code));
    check("busy",  32'(bus.busy),  32'(code != 0));
    check("done",  32'(bus.done),  32'(code == 8));
    check("level", 32'(bus.water_level), 32'(lvl));
  endtask

  task automatic step(input int code, input int lvl);
    @(posedge clk);
    #1;
    check_all(code, lvl);
  endtask

  task automatic request(input int c, input int lvl);
    bus.cups  = 3'(c);
    bus.start = 1'b1;
    step(1, lvl);
    bus.start = 1'b0;
  endtask

  // ENCHER: level rises by one after every third cycle.
  task automatic fill_seq(input int ncyc, input int lvl0);
    for (int k = 0; k < ncyc; k++) step(3, lvl0 + k / 3);
  endtask

  task automatic heat_grind_filter(input int lvl);
    for (int k = 0; k < 4; k++) step(4, lvl);
    for (int k = 0; k < 2; k++) step(5, lvl);
    step(6, lvl);
  endtask

  // PASSAR: level drops by one at the end of each cup.
  task automatic brew_seq(input int ncups, input int lvl0);
    for (int k = 0; k < 3 * ncups; k++) step(7, lvl0 - k / 3);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.cups  = 3'd0;

    #3;
    check_all(0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0);

    phase = "cold";
    request(1, 0);
    step(2, 0);
    fill_seq(12, 0);
    heat_grind_filter(4);
    brew_seq(1, 4);
    step(8, 3);
    step(0, 3);

    phase = "warm";
    request(2, 3);
    step(2, 3);
    heat_grind_filter(3);
    brew_seq(2, 3);
    step(8, 1);
    step(0, 1);

    phase = "short";
    request(3, 1);
    step(2, 1);
    fill_seq(9, 1);
    heat_grind_filter(4);
    brew_seq(3, 4);
    step(8, 1);
    step(0, 1);

    phase = "abort";
    request(1, 1);
    bus.start = 1'b1;
    bus.cups  = 3'd3;
    step(2, 1);
    bus.start = 1'b0;
    step(4, 1);
    step(4, 1);
    bus.abort = 1'b1;
    step(9, 1);
    bus.abort = 1'b0;
    step(0, 1);
    step(0, 1);

    phase = "cups0";
    request(0, 1);
    step(2, 1);
    heat_grind_filter(1);
    brew_seq(1, 1);
    step(8, 0);
    step(0, 0);

    phase = "cups7";
    request(7, 0);
    step(2, 0);
    fill_seq(12, 0);
    heat_grind_filter(4);
    brew_seq(4, 4);
    step(8, 0);
    step(0, 0);

    phase = "idle_abort";
    bus.abort = 1'b1;
    step(0, 0);
    bus.abort = 1'b0;

    phase = "midreset";
    request(1, 0);
    step(2, 0);
    fill_seq(7, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all(0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maquina_cafe_param.md
Name: maquina_cafe_param

Overview:
Parametrised coffee-machine sequencer: the next generation of the single-cup water/heat/brew FSM. Adds a multi-cup request, a reservoir level counter with configurable capacity, configurable per-phase durations, and an abort path. It sits between the front-panel inputs and the actuator drivers, which decode the 4-bit state code.

Parameters:
WATER_CAP, 4, reservoir capacity in doses (1 dose = 1 cup); level width = $clog2(WATER_CAP+1)
MAX_CUPS, 4, largest cup count served per request; must be <= WATER_CAP
FILL_CYCLES, 3, cycles to add one dose while filling
HEAT_CYCLES, 4, cycles spent in AQUECER
GRIND_CYCLES, 2, cycles spent in MOER
BREW_CYCLES, 3, cycles per cup in PASSAR

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request pulse; sampled only in IDLE
abort  in  1  cancel request; ignored in IDLE, SERVIR and ABORTAR
cups  in  $clog2(MAX_CUPS+1)  cups requested; latched with start
state  out  4  current state code
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse while in SERVIR
water_level  out  $clog2(WATER_CAP+1)  doses currently in the reservoir

Behaviour:
- Reset (async, rst_n=0): state=IDLE(0), water_level=0, latched cups=0, timer=0; busy=0, done=0.
- State codes: IDLE=0, LIGAR=1, VERIFICAR_AGUA=2, ENCHER=3, AQUECER=4, MOER=5, COLOCAR_FILTRO=6, PASSAR=7, SERVIR=8, ABORTAR=9. Codes 10-15 are unreachable; if entered, go to IDLE on the next edge.
- One shared down/up timer. Every state resets it on entry. A timed state leaves when timer==duration-1.
- IDLE: on start=1, latch n=cups (0 -> 1; >MAX_CUPS -> MAX_CUPS) and go to LIGAR. start in any other state is ignored.
- LIGAR: 1 cycle, then VERIFICAR_AGUA.
- VERIFICAR_AGUA: 1 cycle. If water_level >= n, go to AQUECER; else go to ENCHER.
- ENCHER: water_level increments by 1 every FILL_CYCLES cycles. Exit to AQUECER on the same edge level reaches WATER_CAP, so the duration is (WATER_CAP-level)*FILL_CYCLES. The level saturates and never exceeds WATER_CAP.
- AQUECER: HEAT_CYCLES cycles. MOER: GRIND_CYCLES cycles. COLOCAR_FILTRO: 1 cycle.
- PASSAR: n*BREW_CYCLES cycles. water_level decrements by 1 at the end of each cup. Go to SERVIR after the last cup.
- SERVIR: 1 cycle with done=1, then IDLE.
- Abort: in a non-IDLE, non-SERVIR, non-ABORTAR state, abort=1 at an edge goes to ABORTAR. Abort takes priority over any simultaneous normal transition. On an abort edge, no increment or decrement happens that edge. Partial doses and partial cups are discarded; completed ones stay counted. ABORTAR lasts 1 cycle, then IDLE; done is not pulsed.
- water_level persists across requests; only rst_n clears it.
- Reset mid-operation: immediate return to the reset values, with no done pulse.

Decomposition:
- Shared package maquina_pkg: 4-bit state enum/localparams (IDLE..ABORTAR) for reuse by the actuator decoder and benches; a dose-width helper function.
- One natural sub-module: maquina_timer, a loadable cycle counter with clear and terminal-count flag.
- FSM and level counter stay in the top module.

Test Plan:
- Cold start, water_level=0, cups=1, start pulse: states 1,2,3(x12, level 0->4),4(x4),5(x2),6(x1),7(x3),8(x1),0. done pulses once; final level=3.
- Warm start, level=3, cups=2: 1,2 then straight to 4 (no ENCHER); PASSAR lasts 6 cycles; level 3->2->1; done=1 at state 8.
- Insufficient water, level=1, cups=3: ENCHER lasts 9 cycles (1->4); after PASSAR, level=1.
- Abort asserted at the 2nd AQUECER cycle: next state 9, then 0. done stays 0, level unchanged, busy falls with IDLE. A start pulse during the busy period before the abort is ignored.
- cups=0 gives a 3-cycle PASSAR; cups=7 (MAX_CUPS=4) gives a 12-cycle PASSAR with level 4->0.
- rst_n low in the middle of ENCHER (level=2): state=0 and level=0 immediately, without waiting for a clock edge. After release, IDLE holds until start.
